// File: rtl/avr_prefetch.sv
// AVR program-word prefetch queue: fetch FSM, two-word opcode decode,
// advance/skip/jump PC control with flush and in-flight drop.
module avr_prefetch #(
    parameter int PC_W      = 16,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      pc_src,
    input  logic [PC_W-1:0] jmp,
    output logic            prog_req,
    output logic [PC_W-1:0] prog_addr,
    input  logic            prog_ack,
    input  logic [15:0]     prog_data,
    output logic [15:0]     cur_instr,
    output logic [15:0]     cur_instr2,
    output logic            instr_len,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_W-1:0] RV      = PC_W'(RESET_VEC);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t          r_st;
    logic            r_req;
    logic [15:0]     r_q [DEPTH];
    logic [AW-1:0]   r_head;
    logic [CW-1:0]   r_cnt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_fpc;
    logic [PC_W-1:0] r_addr;
    logic            r_skip;

    logic [15:0]     w_head;
    logic            w_two;
    logic            w_cmpl;
    logic            w_jump;
    logic            w_step;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW-1:0]   w_need;
    logic [CW-1:0]   w_cnt_nxt;
    logic [AW-1:0]   w_tail;
    logic [PC_W-1:0] w_tgt;
    logic [PC_W-1:0] w_fpc_nxt;

    // An empty queue presents a zero head word, which decodes as one-word.
    assign w_head = (r_cnt != '0) ? r_q[r_head] : 16'h0000;
    assign w_two  = ((w_head & 16'hFE0C) == 16'h940C) ||
                    ((w_head & 16'hFC0F) == 16'h9000);
    assign w_need = w_two ? CW'(2) : CW'(1);
    assign w_cmpl = (r_cnt >= w_need);

    assign w_jump = (pc_src == 3'b100) || (pc_src == 3'b101);
    assign w_tgt  = pc_src[0] ? (r_pc + PC_W'(1) + jmp) : jmp;
    assign w_step = ((pc_src == 3'b010) || (pc_src == 3'b011)) &&
                    w_cmpl && !r_skip;
    assign w_pop  = !w_jump && (w_step || (r_skip && w_cmpl));
    assign w_push = prog_ack && (r_st == S_REQ) && !w_jump;
    assign w_tail = r_head + r_cnt[AW-1:0];

    assign w_cnt_nxt = w_jump ? '0 :
                       (r_cnt + CW'(w_push) - (w_pop ? w_need : '0));
    assign w_fpc_nxt = w_jump ? w_tgt :
                       (w_push ? (r_fpc + PC_W'(1)) : r_fpc);
    assign w_issue   = (w_cnt_nxt < CNT_MAX);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q[w_tail] <= prog_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc   <= RV;
            r_fpc  <= RV;
            r_head <= '0;
            r_cnt  <= '0;
            r_skip <= 1'b0;
        end else begin
            r_fpc <= w_fpc_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_jump) begin
                r_pc   <= w_tgt;
                r_head <= '0;
                r_skip <= 1'b0;
            end else if (w_pop) begin
                r_pc   <= r_pc + PC_W'(w_need);
                r_head <= r_head + w_need[AW-1:0];
                r_skip <= w_step && (pc_src == 3'b011);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_st   <= S_IDLE;
            r_req  <= 1'b0;
            r_addr <= RV;
        end else begin
            unique case (r_st)
                S_IDLE: begin
                    if (w_issue) begin
                        r_st   <= S_REQ;
                        r_req  <= 1'b1;
                        r_addr <= w_fpc_nxt;
                    end
                end
                S_REQ: begin
                    if (prog_ack) begin
                        if (w_issue) begin
                            r_addr <= w_fpc_nxt;
                        end else begin
                            r_st  <= S_IDLE;
                            r_req <= 1'b0;
                        end
                    end else if (w_jump) begin
                        r_st <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (prog_ack) begin
                        r_st  <= S_IDLE;
                        r_req <= 1'b0;
                    end
                end
                default: begin
                    r_st  <= S_IDLE;
                    r_req <= 1'b0;
                end
            endcase
        end
    end

    assign prog_req    = r_req;
    assign prog_addr   = r_addr;
    assign cur_instr   = w_head;
    assign cur_instr2  = (w_two && (r_cnt >= CW'(2))) ?
                         r_q[r_head + AW'(1)] : 16'h0000;
    assign instr_len   = w_two;
    assign instr_valid = w_cmpl && !r_skip;
    assign pc          = r_pc;

endmodule

// File: tb/tb_avr_prefetch.sv
// Self-checking bench for avr_prefetch: default instance plus a
// PC_W=10 / DEPTH=8 instance for reset and address-wrap runs.
module tb_avr_prefetch;
    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic [2:0]  pc_src;
    logic [15:0] jmp;
    logic        prog_req;
    logic [15:0] prog_addr;
    logic        prog_ack;
    logic [15:0] prog_data;
    logic [15:0] cur_instr;
    logic [15:0] cur_instr2;
    logic        instr_len;
    logic        instr_valid;
    logic [15:0] pc;

    logic        RST2;
    logic [2:0]  pc_src2;
    logic [9:0]  jmp2;
    logic        prog_req2;
    logic [9:0]  prog_addr2;
    logic        prog_ack2;
    logic [15:0] prog_data2;
    logic [15:0] cur_instr_2;
    logic [15:0] cur_instr2_2;
    logic        instr_len2;
    logic        instr_valid2;
    logic [9:0]  pc2;

    avr_prefetch u_dut (
        .CLK(CLK), .RST(RST), .pc_src(pc_src), .jmp(jmp),
        .prog_req(prog_req), .prog_addr(prog_addr),
        .prog_ack(prog_ack), .prog_data(prog_data),
        .cur_instr(cur_instr), .cur_instr2(cur_instr2),
        .instr_len(instr_len), .instr_valid(instr_valid), .pc(pc)
    );

    avr_prefetch #(.PC_W(10), .DEPTH(8), .RESET_VEC(0)) u_dut2 (
        .CLK(CLK), .RST(RST2), .pc_src(pc_src2), .jmp(jmp2),
        .prog_req(prog_req2), .prog_addr(prog_addr2),
        .prog_ack(prog_ack2), .prog_data(prog_data2),
        .cur_instr(cur_instr_2), .cur_instr2(cur_instr2_2),
        .instr_len(instr_len2), .instr_valid(instr_valid2), .pc(pc2)
    );

    // Memory for the default instance: programmable ack latency.
    logic [15:0] pmem [65536];
    int lat    = 0;
    int r_wait = 0;
    assign prog_ack  = prog_req && (r_wait >= lat);
    assign prog_data = pmem[prog_addr];
    always @(posedge CLK) begin
        if (!prog_req || prog_ack) r_wait <= 0;
        else r_wait <= r_wait + 1;
    end

    function automatic logic [15:0] m2(input logic [9:0] a);
        if (a == 10'h3FF) return 16'h940C;
        return 16'h4000 | {6'b0, a};
    endfunction
    assign prog_ack2  = prog_req2;
    assign prog_data2 = m2(prog_addr2);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(instr_valid), 32'd1);
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  src;
        logic [15:0] jmp;
        logic [15:0] pc;
        bit          cv;
    } vec_t;
    vec_t vt[9];

    initial begin
        exp_t e;
        int   n;
        int   miss;

        vt[0] = '{3'b100, 16'h0010, 16'h0010, 1'b1};
        vt[1] = '{3'b101, 16'hFFFE, 16'h000F, 1'b1};
        vt[2] = '{3'b101, 16'h0005, 16'h0015, 1'b1};
        vt[3] = '{3'b000, 16'h1234, 16'h0015, 1'b0};
        vt[4] = '{3'b001, 16'h1234, 16'h0015, 1'b0};
        vt[5] = '{3'b110, 16'h1234, 16'h0015, 1'b0};
        vt[6] = '{3'b111, 16'h1234, 16'h0015, 1'b0};
        vt[7] = '{3'b100, 16'hFFFF, 16'hFFFF, 1'b1};
        vt[8] = '{3'b101, 16'h0000, 16'h0000, 1'b1};

        for (int i = 0; i < 65536; i++) pmem[i] = 16'(i);
        RST = 1'b1; RST2 = 1'b1;
        pc_src = 3'b000; jmp = '0;
        pc_src2 = 3'b000; jmp2 = '0;

        repeat (3) @(negedge CLK);
        chk("rst_pc", pc, 0);
        chk("rst_req", 32'(prog_req), 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_len", 32'(instr_len), 0);
        chk("rst_ins", cur_instr, 0);
        chk("rst_ins2", cur_instr2, 0);
        RST = 1'b0;

        // Prime until full, then stream one instruction per cycle.
        repeat (8) @(negedge CLK);
        chk("full_noreq", 32'(prog_req), 0);
        chk("full_valid", 32'(instr_valid), 1);
        chk("full_pc", pc, 0);
        for (int k = 0; k < 20; k++) sb.push_back('{16'(k), 16'(k)});
        pc_src = 3'b010;
        miss = 0;
        for (int k = 0; k < 20; k++) begin
            if (instr_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk("seq_pc", pc, e.pc);
                chk("seq_ins", cur_instr, e.ins);
            end else begin
                miss++;
            end
            @(negedge CLK);
        end
        pc_src = 3'b000;
        chk("seq_stall", miss, 0);

        // Jump / hold vectors.
        for (int i = 0; i < 9; i++) begin
            pc_src = vt[i].src;
            jmp    = vt[i].jmp;
            @(negedge CLK);
            chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
            if (vt[i].cv) chk($sformatf("vec%0d_valid", i),
                              32'(instr_valid), 0);
        end
        pc_src = 3'b000;

        // Two-word JMP at pc=4.
        pmem[4] = 16'h940C;
        pmem[5] = 16'h0050;
        pc_src = 3'b100; jmp = 16'h0003;
        @(negedge CLK);
        pc_src = 3'b000;
        wait_valid("b_v3");
        chk("b_pc3", pc, 3);
        pc_src = 3'b010;
        @(negedge CLK);
        pc_src = 3'b000;
        wait_valid("b_v4");
        chk("b_pc4", pc, 4);
        chk("b_len", 32'(instr_len), 1);
        chk("b_ins", cur_instr, 16'h940C);
        chk("b_ins2", cur_instr2, 16'h0050);
        pc_src = 3'b010;
        @(negedge CLK);
        pc_src = 3'b000;
        wait_valid("b_v6");
        chk("b_pc6", pc, 6);
        chk("b_ins6", cur_instr, 6);

        // Jump while a slow request is in flight.
        lat = 3;
        pc_src = 3'b100; jmp = 16'h0020;
        @(negedge CLK);
        pc_src = 3'b000;
        n = 0;
        while (!(prog_req && prog_addr == 16'h0020) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("c_req20", 32'(prog_req && prog_addr == 16'h0020), 1);
        pc_src = 3'b100; jmp = 16'h0050;
        @(negedge CLK);
        pc_src = 3'b000;
        chk("c_pc", pc, 16'h0050);
        chk("c_valid0", 32'(instr_valid), 0);
        chk("c_hold_addr", {15'b0, prog_req, prog_addr}, {16'h1, 16'h0020});
        n = 0;
        while (prog_req && n < 40) begin @(negedge CLK); n++; end
        while (!prog_req && n < 40) begin @(negedge CLK); n++; end
        chk("c_newaddr", {15'b0, prog_req, prog_addr}, {16'h1, 16'h0050});
        wait_valid("c_v");
        chk("c_ins", cur_instr, 16'h0050);
        chk("c_pc2", pc, 16'h0050);
        lat = 0;

        // Skip over a two-word LDS.
        pmem[3] = 16'h9000;
        pmem[4] = 16'h0004;
        pmem[5] = 16'h0005;
        pc_src = 3'b100; jmp = 16'h0002;
        @(negedge CLK);
        pc_src = 3'b000;
        wait_valid("d_v2");
        repeat (6) @(negedge CLK);
        chk("d_pc2", pc, 2);
        pc_src = 3'b011;
        @(negedge CLK);
        pc_src = 3'b010;
        chk("d_pc3", pc, 3);
        chk("d_valid3", 32'(instr_valid), 0);
        @(negedge CLK);
        pc_src = 3'b000;
        chk("d_pc5", pc, 5);
        chk("d_valid5", 32'(instr_valid), 1);
        chk("d_ins5", cur_instr, 5);

        // Small instance: reset mid-burst near the top of memory.
        RST2 = 1'b0;
        pc_src2 = 3'b100; jmp2 = 10'h3F8;
        @(negedge CLK);
        pc_src2 = 3'b010;
        n = 0;
        while (pc2 != 10'h3FC && n < 40) begin @(negedge CLK); n++; end
        chk("e_pc3fc", pc2, 10'h3FC);
        #2 RST2 = 1'b1;
        #1;
        chk("e_rst_pc", pc2, 0);
        chk("e_rst_req", 32'(prog_req2), 0);
        chk("e_rst_addr", prog_addr2, 0);
        chk("e_rst_valid", 32'(instr_valid2), 0);
        chk("e_rst_len", 32'(instr_len2), 0);
        chk("e_rst_ins", cur_instr_2, 0);
        chk("e_rst_ins2", cur_instr2_2, 0);
        @(negedge CLK);
        chk("e_rst_hold", {16'(prog_req2), 6'b0, pc2}, 0);
        RST2 = 1'b0;
        pc_src2 = 3'b000;
        @(negedge CLK);
        chk("e_restart", {15'b0, prog_req2, 6'b0, prog_addr2}, {16'h1, 16'h0});

        // Second run across the 3FF -> 000 wrap with a straddling JMP.
        pc_src2 = 3'b100; jmp2 = 10'h3FD;
        @(negedge CLK);
        pc_src2 = 3'b010;
        sb.push_back('{16'h03FD, 16'h43FD});
        sb.push_back('{16'h03FE, 16'h43FE});
        sb.push_back('{16'h03FF, 16'h940C});
        sb.push_back('{16'h0001, 16'h4001});
        sb.push_back('{16'h0002, 16'h4002});
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            if (instr_valid2) begin
                e = sb.pop_front();
                chk("w_pc", pc2, e.pc);
                chk("w_ins", cur_instr_2, e.ins);
                if (e.pc == 16'h03FF) begin
                    chk("w_len", 32'(instr_len2), 1);
                    chk("w_ins2", cur_instr2_2, 16'h4000);
                end
            end
            @(negedge CLK);
            n++;
        end
        pc_src2 = 3'b000;
        chk("w_done", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
